// File: rtl/icosoc_fifo_wordpacker.sv
// Drains a byte-wide show-ahead FIFO and packs LANES entries per output word.
// Partial words leave on flush or after an idle timeout, tagged with a lane count.
module icosoc_fifo_wordpacker #(
  parameter int WIDTH   = 8,
  parameter int LANES   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fifo_nempty,
  input  logic [WIDTH-1:0]           fifo_data,
  output logic                       fifo_pop,
  input  logic                       flush,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [WIDTH*LANES-1:0]     word_data,
  output logic [$clog2(LANES+1)-1:0] word_bytes,
  output logic                       busy,
  output logic [15:0]                stat_words
);

  localparam int DW = WIDTH * LANES;
  localparam int FW = $clog2(LANES);
  localparam int BW = $clog2(LANES + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [DW-1:0] r_acc;
  logic [FW-1:0] r_fill;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [BW-1:0] r_bytes;
  logic          r_pend;
  logic [IW-1:0] r_idle;
  logic [15:0]   r_stat;

  logic          w_free;
  logic          w_last;
  logic          w_tmo;
  logic          w_part;
  logic          w_pop;
  logic          w_full;
  logic          w_load;
  logic [DW-1:0] w_acc_nx;
  logic [BW-1:0] w_bytes_nx;

  assign w_free = !r_valid || word_ready;
  assign w_last = (r_fill == FW'(LANES - 1));
  assign w_tmo  = (TIMEOUT != 0) && (r_idle == IW'(TIMEOUT));
  assign w_part = (r_pend || w_tmo) && (r_fill != '0);

  // Stall the FIFO whenever this cycle would need the output register
  assign w_pop = !reset && fifo_nempty
               && !(w_last && !w_free)
               && !(w_part && !w_free);

  assign w_full = w_pop && w_last;
  assign w_load = w_full || (w_part && w_free);

  always_comb begin
    w_acc_nx = r_acc;
    for (int i = 0; i < LANES; i++) begin
      if (w_pop && (r_fill == FW'(i))) begin
        w_acc_nx[i*WIDTH +: WIDTH] = fifo_data;
      end
    end
  end

  assign w_bytes_nx = w_full ? BW'(LANES)
                             : BW'(r_fill) + BW'(w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_bytes <= '0;
      r_pend  <= 1'b0;
      r_idle  <= '0;
      r_stat  <= '0;
    end else begin
      r_stat <= r_stat + 16'(r_valid && word_ready);

      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_acc_nx;
        r_bytes <= w_bytes_nx;
      end else if (word_ready) begin
        r_valid <= 1'b0;
      end

      if (w_load) begin
        r_acc  <= '0;
        r_fill <= '0;
      end else if (w_pop) begin
        r_acc  <= w_acc_nx;
        r_fill <= r_fill + FW'(1);
      end

      // A flush that lands on the completing pop needs no follow-up word
      if (w_load) begin
        r_pend <= 1'b0;
      end else if (flush && ((r_fill != '0) || w_pop)) begin
        r_pend <= 1'b1;
      end

      if (w_load || w_pop || (r_fill == '0)) begin
        r_idle <= '0;
      end else if (r_idle != IW'(TIMEOUT)) begin
        r_idle <= r_idle + IW'(1);
      end
    end
  end

  assign fifo_pop   = w_pop;
  assign word_valid = r_valid;
  assign word_data  = r_data;
  assign word_bytes = r_bytes;
  assign busy       = (r_fill != '0) || r_valid;
  assign stat_words = r_stat;

endmodule

// File: tb/tb_icosoc_fifo_wordpacker.sv
// Directed bench for icosoc_fifo_wordpacker: packing, back-pressure,
// flush, idle timeout and mid-word reset.
module tb_icosoc_fifo_wordpacker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fifo_nempty;
  logic [7:0]  fifo_data;
  logic        fifo_pop;
  logic        flush;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        busy;
  logic [15:0] stat_words;

  logic        z_nempty;
  logic [7:0]  z_fdata;
  logic        z_pop;
  logic        z_flush;
  logic        z_valid;
  logic        z_ready;
  logic [31:0] z_data;
  logic [2:0]  z_bytes;
  logic        z_busy;
  logic [15:0] z_stat;

  icosoc_fifo_wordpacker #(.WIDTH(8), .LANES(4), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .fifo_nempty(fifo_nempty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
    .flush(flush),
    .word_valid(word_valid), .word_ready(word_ready),
    .word_data(word_data), .word_bytes(word_bytes),
    .busy(busy), .stat_words(stat_words)
  );

  icosoc_fifo_wordpacker #(.WIDTH(8), .LANES(4), .TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset),
    .fifo_nempty(z_nempty), .fifo_data(z_fdata), .fifo_pop(z_pop),
    .flush(z_flush),
    .word_valid(z_valid), .word_ready(z_ready),
    .word_data(z_data), .word_bytes(z_bytes),
    .busy(z_busy), .stat_words(z_stat)
  );

  logic [7:0]  q[$];
  logic [7:0]  zq[$];
  logic [34:0] acc_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          last_pop;
  bit          last_zpop;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [34:0] acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : 35'h0;
  endfunction

  task automatic drive_fifo();
    fifo_nempty = (q.size() != 0);
    fifo_data   = (q.size() != 0) ? q[0] : 8'h00;
    z_nempty    = (zq.size() != 0);
    z_fdata     = (zq.size() != 0) ? zq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    drive_fifo();
  endtask

  // Sample at the falling edge, model the FIFO just after the rising edge
  task automatic tick();
    @(negedge clk);
    last_pop  = fifo_pop;
    last_zpop = z_pop;
    if (!reset && word_valid && word_ready)
      acc_q.push_back({word_bytes, word_data});
    @(posedge clk);
    #1;
    if (last_pop)  void'(q.pop_front());
    if (last_zpop) void'(zq.pop_front());
    drive_fifo();
  endtask

  initial begin
    int npop;
    int nv;
    int n;
    int unstable;

    reset = 1'b1; flush = 1'b0; word_ready = 1'b0;
    z_flush = 1'b0; z_ready = 1'b1;
    drive_fifo();
    repeat (2) tick();
    check("rst_valid", word_valid, 1'b0);
    check("rst_data", word_data, 32'h0);
    check("rst_bytes", word_bytes, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_stat", stat_words, 16'h0);
    reset = 1'b0;

    // back-to-back stream
    word_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    npop = 0;
    repeat (3) begin tick(); npop += int'(last_pop); end
    check("t1_early_valid", word_valid, 1'b0);
    tick(); npop += int'(last_pop);
    check("t1_pops", npop, 4);
    check("t1_valid", word_valid, 1'b1);
    check("t1_data", word_data, 32'h44332211);
    check("t1_bytes", word_bytes, 3'd4);
    tick();
    check("t1_stat", stat_words, 16'd1);
    check("t1_idle", busy, 1'b0);

    // back-pressure
    acc_q.delete();
    word_ready = 1'b0;
    for (int i = 0; i < 12; i++) push(8'(i));
    npop = 0; unstable = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      npop += int'(last_pop);
      if (i >= 4 && (word_data !== 32'h03020100 || word_valid !== 1'b1))
        unstable++;
    end
    check("t2_pops", npop, 7);
    check("t2_stall_pop", fifo_pop, 1'b0);
    check("t2_nempty", fifo_nempty, 1'b1);
    check("t2_stable", unstable, 0);
    check("t2_hold", word_data, 32'h03020100);
    word_ready = 1'b1;
    tick();
    check("t2_nobubble_v", word_valid, 1'b1);
    check("t2_nobubble_d", word_data, 32'h07060504);
    n = 0;
    while (acc_q.size() < 3 && n < 20) begin tick(); n++; end
    check("t2_words", acc_q.size(), 3);
    check("t2_w0", acc_at(0), {3'd4, 32'h03020100});
    check("t2_w1", acc_at(1), {3'd4, 32'h07060504});
    check("t2_w2", acc_at(2), {3'd4, 32'h0B0A0908});
    check("t2_stat", stat_words, 16'd4);

    // explicit flush
    acc_q.delete();
    push(8'hAA); push(8'hBB);
    repeat (2) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    check("t3_valid", word_valid, 1'b1);
    check("t3_data", word_data, 32'h0000BBAA);
    check("t3_bytes", word_bytes, 3'd2);
    tick();
    flush = 1'b1; tick(); flush = 1'b0;
    nv = 0;
    repeat (4) begin tick(); nv += int'(word_valid); end
    check("t3_empty_flush", nv, 0);
    check("t3_words", acc_q.size(), 1);
    check("t3_stat", stat_words, 16'd5);

    // idle timeout
    push(8'h5A);
    tick();
    check("t4_pop", last_pop, 1'b1);
    n = 0;
    while (!word_valid && n < 40) begin tick(); n++; end
    check("t4_latency", n, 17);
    check("t4_data", word_data, 32'h0000005A);
    check("t4_bytes", word_bytes, 3'd1);
    tick();
    check("t4_stat", stat_words, 16'd6);

    // timeout disabled
    zq.push_back(8'h5A);
    drive_fifo();
    tick();
    check("t4z_pop", last_zpop, 1'b1);
    nv = 0;
    repeat (1000) begin tick(); nv += int'(z_valid); end
    check("t4z_noemit", nv, 0);
    check("t4z_busy", z_busy, 1'b1);

    // flush coinciding with pops
    acc_q.delete();
    push(8'h01); push(8'h02); push(8'h03);
    repeat (2) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    check("t5_valid", word_valid, 1'b1);
    check("t5_data", word_data, 32'h00030201);
    check("t5_bytes", word_bytes, 3'd3);
    tick();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (3) tick();
    flush = 1'b1; tick(); flush = 1'b0;
    check("t5_full_data", word_data, 32'h44332211);
    check("t5_full_bytes", word_bytes, 3'd4);
    repeat (20) tick();
    check("t5_words", acc_q.size(), 2);
    check("t5_w0", acc_at(0), {3'd3, 32'h00030201});
    check("t5_w1", acc_at(1), {3'd4, 32'h44332211});
    check("t5_stat", stat_words, 16'd8);

    // reset mid-word
    word_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
    repeat (6) tick();
    check("t6_pre_valid", word_valid, 1'b1);
    check("t6_pre_busy", busy, 1'b1);
    reset = 1'b1;
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    #1;
    check("t6_pop_in_reset", fifo_pop, 1'b0);
    tick();
    check("t6_pop_edge", last_pop, 1'b0);
    check("t6_valid", word_valid, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_stat", stat_words, 16'd0);
    check("t6_data", word_data, 32'h0);
    reset = 1'b0;
    word_ready = 1'b1;
    acc_q.delete();
    repeat (4) tick();
    check("t6_clean_v", word_valid, 1'b1);
    check("t6_clean_d", word_data, 32'hC4C3C2C1);
    check("t6_clean_b", word_bytes, 3'd4);
    tick();
    check("t6_words", acc_q.size(), 1);
    check("t6_stat2", stat_words, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
